reverse_sched: RTL and testbench

Front-end scheduler for the digit-reverse core. It accepts numbers on a valid/ready input stream and buffers them in a small FIFO. It launches one core job at a time through the core's `start`/`x`/`Done`/`reverse` handshake, then presents each original/reversed pair on a valid/ready output stream. It sits directly upstream and downstream of the reverse core instance, so the rest of the design never drives `start` or polls `Done`.

---
 rtl/reverse_sched_if.sv | 41 ++++
 rtl/reverse_sched.sv | 154 +++++++++++++++
 tb/tb_reverse_sched.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reverse_sched_if.sv
// reverse_sched_if: input stream, output stream and core handshake
// signals of the digit-reverse scheduler, bundled into one interface.
// The master modport is the scheduler's view; the slave modport is the
// view of everything around it (producer, consumer, reverse core).
// The out_pal signal exists only when REVERSE_SCHED_PAL_EN is defined.
interface reverse_sched_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             core_start;
  logic [WIDTH-1:0] core_x;
  logic             core_done;
  logic [WIDTH-1:0] core_reverse;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_x;
  logic [WIDTH-1:0] out_reverse;
`ifdef REVERSE_SCHED_PAL_EN
  logic             out_pal;

  modport master (
    input  in_valid, in_data, core_done, core_reverse, out_ready,
    output in_ready, core_start, core_x, out_valid, out_x, out_reverse, out_pal
  );
  modport slave (
    output in_valid, in_data, core_done, core_reverse, out_ready,
    input  in_ready, core_start, core_x, out_valid, out_x, out_reverse, out_pal
  );
`else
  modport master (
    input  in_valid, in_data, core_done, core_reverse, out_ready,
    output in_ready, core_start, core_x, out_valid, out_x, out_reverse
  );
  modport slave (
    output in_valid, in_data, core_done, core_reverse, out_ready,
    input  in_ready, core_start, core_x, out_valid, out_x, out_reverse
  );
`endif
endinterface

// File: rtl/reverse_sched.sv
// reverse_sched: front-end scheduler for the digit-reverse core.
// Numbers enter through a small FIFO, one core job runs at a time via a
// start pulse / Done rising edge, and each original/reversed pair is
// presented on the output stream. Results leave in input order.
//
// Handshake rules: a stream transfer happens in a cycle where valid and
// ready are both high at the rising edge; a source that raises valid
// keeps valid and its data stable until that transfer. in_ready is
// !full from registered occupancy, so a full FIFO never accepts a push
// even in a cycle where it pops.
//
// Optional feature macro: REVERSE_SCHED_PAL_EN adds the registered
// out_pal palindrome flag (core_x == core_reverse at capture).
module reverse_sched #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  reverse_sched_if.master            bus,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       busy,
  output logic [1:0]                 dbg_state_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             done_q;
  logic             core_start_q;
  logic [WIDTH-1:0] core_x_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_x_q;
  logic [WIDTH-1:0] out_rev_q;
`ifdef REVERSE_SCHED_PAL_EN
  logic             out_pal_q;
`endif

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic done_rise;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign push      = bus.in_valid & ~full;
  // The FSM takes the head only while idle; this is the FIFO's sole pop.
  assign pop       = (state_q == IDLE) & ~empty;
  // A level already high when WAIT is entered is not a rise.
  assign done_rise = bus.core_done & ~done_q;

  // Occupancy next-state: push and pop together leave it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // FIFO storage; contents are don't-care once the pointers reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_data;
  end

  // Job FSM with registered start pulse, operand and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      done_q       <= 1'b0;
      core_start_q <= 1'b0;
      core_x_q     <= '0;
      out_valid_q  <= 1'b0;
      out_x_q      <= '0;
      out_rev_q    <= '0;
`ifdef REVERSE_SCHED_PAL_EN
      out_pal_q    <= 1'b0;
`endif
    end else begin
      done_q       <= bus.core_done;
      core_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!empty) begin
            core_x_q     <= mem_q[rd_ptr_q];
            core_start_q <= 1'b1;
            state_q      <= LAUNCH;
          end
        end
        LAUNCH: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (done_rise) begin
            out_x_q     <= core_x_q;
            out_rev_q   <= bus.core_reverse;
            out_valid_q <= 1'b1;
`ifdef REVERSE_SCHED_PAL_EN
            out_pal_q   <= (core_x_q == bus.core_reverse);
`endif
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = ~full;
  assign bus.core_start  = core_start_q;
  assign bus.core_x      = core_x_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_x       = out_x_q;
  assign bus.out_reverse = out_rev_q;
`ifdef REVERSE_SCHED_PAL_EN
  assign bus.out_pal     = out_pal_q;
`endif
  assign count           = count_q;
  assign busy            = (state_q != IDLE);
  assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_reverse_sched.sv
// tb_reverse_sched: randomized and directed bench for reverse_sched with
// a behavioural reverse-core model and a queue-based reference model.
module tb_reverse_sched;
  localparam int W  = 16;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reverse_sched_if #(.WIDTH(W)) bus();
  logic [CW-1:0] count;
  logic          busy;
  logic [1:0]    dbg_state;

  reverse_sched #(.WIDTH(W), .DEPTH(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .count       (count),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Decimal digit reversal, straight from the definition.
  function automatic int rev_dec(input int v);
    int r;
    r = 0;
    while (v > 0) begin
      r = r * 10 + (v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // ---------------- reverse core model ----------------
  // Done falls 1-2 cycles after start (so a stale high level is seen in
  // WAIT), rises 3-8 cycles after start with the result. Between jobs it
  // glitches Done with garbage data to create edges that must be ignored.
  int         c_cnt;
  int         c_lat;
  int         c_drop;
  logic [W-1:0] c_x;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.core_done    <= 1'b0;
      bus.core_reverse <= '0;
      c_cnt            <= 0;
      c_lat            <= 3;
      c_drop           <= 1;
      c_x              <= '0;
    end else if (bus.core_start) begin
      c_cnt  <= 1;
      c_lat  <= $urandom_range(3, 8);
      c_drop <= $urandom_range(1, 2);
      c_x    <= bus.core_x;
    end else if (c_cnt != 0) begin
      c_cnt <= c_cnt + 1;
      if (c_cnt == c_drop) bus.core_done <= 1'b0;
      if (c_cnt == c_lat) begin
        bus.core_done    <= 1'b1;
        bus.core_reverse <= W'(rev_dec(int'(c_x)));
        c_cnt            <= 0;
      end
    end else if ($urandom_range(0, 5) == 0) begin
      bus.core_done    <= ~bus.core_done;
      bus.core_reverse <= W'($urandom);
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           model_count = 0;
  int           starts      = 0;
  bit           in_flight   = 0;
  bit           prev_start  = 0;
  bit           prev_hold   = 0;
  logic [W-1:0] prev_x;
  logic [W-1:0] prev_rev;

  // Accepted pushes: the model accepts whenever its FIFO is not full.
  initial forever begin
    @(posedge clk);
    if (rst_n && bus.in_valid && (model_count < D)) begin
      exp_q.push_back(bus.in_data);
      model_count++;
    end
  end

  // Per-cycle checks away from the active edge.
  initial forever begin
    logic [W-1:0] x;
    @(negedge clk);
    if (!rst_n) begin
      prev_start = 0;
      prev_hold  = 0;
    end else begin
      if (bus.core_start) begin
        model_count--;
        starts++;
        in_flight = 1;
      end
      check("count", count, model_count);
      check("in_ready", bus.in_ready, (model_count < D));
      check("busy", busy, in_flight);
      if (prev_start) check("start_width", bus.core_start, 0);
      check("start_while_valid", bus.core_start & bus.out_valid, 0);
      if (prev_hold) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_x", bus.out_x, prev_x);
        check("hold_rev", bus.out_reverse, prev_rev);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", bus.out_valid, 0);
        end else begin
          x = exp_q.pop_front();
          check("out_x", bus.out_x, x);
          check("out_reverse", bus.out_reverse, rev_dec(int'(x)));
`ifdef REVERSE_SCHED_PAL_EN
          check("out_pal", bus.out_pal, (int'(x) == rev_dec(int'(x))));
`endif
        end
        in_flight = 0;
      end
      prev_start = bus.core_start;
      prev_hold  = bus.out_valid && !bus.out_ready;
      prev_x     = bus.out_x;
      prev_rev   = bus.out_reverse;
    end
  end

  // ---------------- driver tasks ----------------
  bit rand_rdy = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
  end

  task automatic push(input logic [W-1:0] v);
    int n;
    bit ok;
    n  = 0;
    ok = 0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    do begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      n++;
    end while (!ok && n < 300);
    #1;
    bus.in_valid = 1'b0;
    if (!ok) check("push_timeout", bus.in_ready, 1);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1;
    bus.out_ready = r;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    check("drain_busy", busy, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_count"}, count, 0);
    check({tag, "_in_ready"}, bus.in_ready, 1);
    check({tag, "_core_start"}, bus.core_start, 0);
    check({tag, "_core_x"}, bus.core_x, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_x"}, bus.out_x, 0);
    check({tag, "_out_reverse"}, bus.out_reverse, 0);
    check({tag, "_busy"}, busy, 0);
`ifdef REVERSE_SCHED_PAL_EN
    check({tag, "_out_pal"}, bus.out_pal, 0);
`endif
  endtask

  task automatic flush_model();
    exp_q.delete();
    model_count = 0;
    in_flight   = 0;
    prev_start  = 0;
    prev_hold   = 0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int s0;
    int n;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset values, during and after reset.
    #12;
    check_reset_vals("rst_in");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_out");

    // Single job: start pulse two cycles after the push edge.
    set_ready(1'b1);
    push(16'd1234);
    @(negedge clk);
    check("lat_n1_start", bus.core_start, 0);
    @(negedge clk);
    check("lat_n2_start", bus.core_start, 1);
    check("lat_n2_core_x", bus.core_x, 1234);
    @(negedge clk);
    check("lat_n3_start", bus.core_start, 0);
    wait_drain(100);
    check("single_count", count, 0);

    // Trailing zeros and zero: exactly two jobs.
    s0 = starts;
    push(16'd120);
    push(16'd0);
    wait_drain(200);
    check("two_starts", starts - s0, 2);

    // Full FIFO with output backpressure: one job parks in HOLD, four fill.
    set_ready(1'b0);
    for (int i = 0; i < 5; i++) push(W'(100 + i * 11));
    repeat (12) @(negedge clk);
    check("full_count", count, D);
    check("full_in_ready", bus.in_ready, 0);
    check("full_out_valid", bus.out_valid, 1);
    s0 = starts;
    fork
      push(16'd777);
      begin
        repeat (10) @(negedge clk);
        check("bp_no_start", starts - s0, 0);
        check("bp_still_full", bus.in_ready, 0);
        check("bp_out_x", bus.out_x, 100);
        set_ready(1'b1);
      end
    join
    wait_drain(400);

    // Palindrome pair.
    push(16'd12321);
    push(16'd12345);
    wait_drain(200);

    // Reset during WAIT of a job.
    push(16'd11);
    push(16'd22);
    push(16'd33);
    n = 0;
    while (dbg_state != 2'd2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_wait", dbg_state, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    flush_model();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("post_rst");
    push(16'd56);
    wait_drain(200);

    // Randomized traffic with random output backpressure.
    rand_rdy = 1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      push(W'($urandom_range(0, 9999)));
    end
    rand_rdy = 0;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    wait_drain(2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
